// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file and exception/ERET commit unit.
// Serves MFC0/MTC0 from decode, records precise exceptions and ERETs from
// the commit end of the pipeline, runs the Count/Compare timer and drives
// the interrupt request plus the one-cycle pipeline redirect.
module cp0_regfile #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter logic [31:0] PRID_VAL   = 32'h0000_4220
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cp0_write,
   input  logic [4:0]  cp0_idx,
   input  logic [31:0] cp0_data2w,
   output logic [31:0] cp0_val,
   output logic [31:0] d_epc,
   input  logic [5:0]  exc_code,
   input  logic [31:0] exc_pc,
   input  logic        exc_bd,
   input  logic [31:0] exc_badvaddr,
   input  logic        eret_commit,
   input  logic [5:0]  ext_int,
   output logic        int_req,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        status_exl
);

   localparam logic [4:0] IDX_BADVADDR = 5'd8;
   localparam logic [4:0] IDX_COUNT    = 5'd9;
   localparam logic [4:0] IDX_COMPARE  = 5'd11;
   localparam logic [4:0] IDX_STATUS   = 5'd12;
   localparam logic [4:0] IDX_CAUSE    = 5'd13;
   localparam logic [4:0] IDX_EPC      = 5'd14;
   localparam logic [4:0] IDX_PRID     = 5'd15;

   logic [31:0] badvaddr;
   logic [31:0] count;
   logic        tick;
   logic [31:0] compare;
   logic [7:0]  status_im;
   logic        status_ie;
   logic        cause_bd;
   logic        cause_ti;
   logic [1:0]  cause_ip_sw;
   logic [5:0]  ext_q;
   logic [4:0]  cause_exc;
   logic [31:0] epc;

   logic        exc_valid;
   logic        eret_do;
   logic        mtc0_do;
   logic        wr_count;
   logic        wr_compare;
   logic        wr_status;
   logic        wr_cause;
   logic        wr_epc;
   logic [7:0]  ip;
   logic [31:0] status_val;
   logic [31:0] cause_val;

   // Commit arbitration: an exception suppresses ERET and MTC0, ERET suppresses MTC0
   always_comb begin
      exc_valid  = exc_code[5];
      eret_do    = eret_commit & ~exc_valid;
      mtc0_do    = cp0_write & ~exc_valid & ~eret_commit;
      wr_count   = mtc0_do && (cp0_idx == IDX_COUNT);
      wr_compare = mtc0_do && (cp0_idx == IDX_COMPARE);
      wr_status  = mtc0_do && (cp0_idx == IDX_STATUS);
      wr_cause   = mtc0_do && (cp0_idx == IDX_CAUSE);
      wr_epc     = mtc0_do && (cp0_idx == IDX_EPC);
   end

   // Assemble the architectural views of Status and Cause; IP[7] folds in the timer
   always_comb begin
      ip         = {ext_q[5] | cause_ti, ext_q[4:0], cause_ip_sw};
      status_val = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
      cause_val  = {cause_bd, cause_ti, 14'b0, ip, 1'b0, cause_exc, 2'b0};
   end

   // MFC0 read mux: current register state only, no write bypass
   always_comb begin
      cp0_val = 32'b0;
      case (cp0_idx)
         IDX_BADVADDR: cp0_val = badvaddr;
         IDX_COUNT:    cp0_val = count;
         IDX_COMPARE:  cp0_val = compare;
         IDX_STATUS:   cp0_val = status_val;
         IDX_CAUSE:    cp0_val = cause_val;
         IDX_EPC:      cp0_val = epc;
         IDX_PRID:     cp0_val = PRID_VAL;
         default:      cp0_val = 32'b0;
      endcase
   end

   assign d_epc   = epc;
   assign int_req = status_ie & ~status_exl & (|(ip & status_im));

   // Count advances every other cycle; an MTC0 load wins and realigns the tick
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= 32'b0;
         tick  <= 1'b0;
      end else if (wr_count) begin
         count <= cp0_data2w;
         tick  <= 1'b0;
      end else begin
         tick <= ~tick;
         if (tick) count <= count + 32'd1;
      end
   end

   // Compare register and sticky timer interrupt; writing Compare clears TI and beats a match
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         compare  <= 32'b0;
         cause_ti <= 1'b0;
      end else begin
         if (wr_compare) compare <= cp0_data2w;
         if (wr_compare)            cause_ti <= 1'b0;
         else if (count == compare) cause_ti <= 1'b1;
      end
   end

   // Hardware interrupt lines are sampled into Cause.IP every cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) ext_q <= 6'b0;
      else         ext_q <= ext_int;
   end

   // Status: exception sets EXL, ERET clears it, MTC0 writes IM/EXL/IE
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         status_im  <= 8'b0;
         status_exl <= 1'b0;
         status_ie  <= 1'b0;
      end else if (exc_valid) begin
         status_exl <= 1'b1;
      end else if (eret_do) begin
         status_exl <= 1'b0;
      end else if (wr_status) begin
         status_im  <= cp0_data2w[15:8];
         status_exl <= cp0_data2w[1];
         status_ie  <= cp0_data2w[0];
      end
   end

   // Cause/EPC: a nested exception (EXL already set) keeps the original EPC and BD
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cause_bd    <= 1'b0;
         cause_exc   <= 5'b0;
         cause_ip_sw <= 2'b0;
         epc         <= 32'b0;
      end else if (exc_valid) begin
         cause_exc <= exc_code[4:0];
         if (!status_exl) begin
            epc      <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
            cause_bd <= exc_bd;
         end
      end else begin
         if (wr_cause) cause_ip_sw <= cp0_data2w[9:8];
         if (wr_epc)   epc         <= cp0_data2w;
      end
   end

   // BadVAddr captures the faulting address for address-error exceptions only
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         badvaddr <= 32'b0;
      end else if (exc_valid && (exc_code[4:0] == 5'd4 || exc_code[4:0] == 5'd5)) begin
         badvaddr <= exc_badvaddr;
      end
   end

   // One-cycle redirect pulse; ERET targets the EPC held before this edge
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         redirect    <= 1'b0;
         redirect_pc <= 32'b0;
      end else begin
         redirect <= exc_valid | eret_do;
         if (exc_valid)    redirect_pc <= EXC_VECTOR;
         else if (eret_do) redirect_pc <= epc;
      end
   end

endmodule
